map_speed_scheduler: RTL and testbench
======================================

MAP_SPEED_SCHEDULER -- requirements
Module: map_speed_scheduler

Interface
REQ-001 SHALL have parameter VEL_W, default 2, width of the velocity input.
REQ-002 SHALL have parameter LEVEL_W, default 2, width of the difficulty level.
REQ-003 SHALL have parameter CNT_W, default 16, width of the period and tick counters.
REQ-004 SHALL have parameter BASE_PERIOD, default 800, ticks between moves at speed 0.
REQ-005 SHALL have parameter STEP, default 100, period reduction per unit of speed.
REQ-006 SHALL have parameter MIN_PERIOD, default 200 (at least 1), floor of the move period.
REQ-007 SHALL have parameter LEVEL_TICKS, default 30000, enabled ticks between level increments.
REQ-008 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-010 SHALL have port count_map, input, 1, run enable; 0 pauses all counters.
REQ-011 SHALL have port velocity, input, VEL_W, player speed request.
REQ-012 SHALL have port clear_level, input, 1, synchronous restart of level and counters.
REQ-013 SHALL have port move_map, output, 1, one-cycle move pulse.
REQ-014 SHALL have port level_up, output, 1, one-cycle pulse on each level increment.
REQ-015 SHALL have port level, output, LEVEL_W, current difficulty level.
REQ-016 SHALL have port period, output, CNT_W, current move period in ticks.

Function
REQ-017 SHALL compute speed = level + velocity at width max(LEVEL_W,VEL_W)+1, with no overflow.
REQ-018 SHALL drive period = max(BASE_PERIOD - STEP*speed, MIN_PERIOD) combinationally from the registered level and the velocity input.
- The subtraction saturates: no wrap-around when STEP*speed exceeds BASE_PERIOD.
REQ-019 SHALL increment the period counter on each edge with count_map=1.
- When the counter is >= period-1 on such an edge: load 0 and register move_map=1 for exactly one cycle.
REQ-020 SHALL apply a period decrease mid-count that leaves counter >= period-1 as follows: fire move_map on the next enabled edge, then continue at the new period.
REQ-021 SHALL advance a level tick counter on each edge with count_map=1.
- At value LEVEL_TICKS-1 it wraps to 0.
- If level < 2^LEVEL_W-1: level increments and level_up=1 for one cycle.
- At max level: level holds and level_up stays 0.
REQ-022 SHALL hold both counters, level, and the move_map/level_up outputs at 0 for any edge with count_map=0.
- Resume from the held counts, with no lost or extra pulse.
REQ-023 SHALL process clear_level=1 on an edge as follows, overriding count_map:
- Zero both counters and level.
- Force move_map=0 and level_up=0.
REQ-024 SHALL fire move_map and level_up in the same cycle when both events coincide; they are independent.

Reset
REQ-025 SHALL, on an edge with reset=0, zero the period counter, level tick counter, level, move_map and level_up, with priority over clear_level and count_map.
REQ-026 SHALL present period = BASE_PERIOD, clamped to MIN_PERIOD, when level=0 and velocity=0 after reset.

Verification (bench params: BASE_PERIOD=8, STEP=2, MIN_PERIOD=2, LEVEL_TICKS=30, CNT_W=8)
REQ-027 SHALL cover reset: reset=0 for 2 edges -> move_map=0, level_up=0, level=0, period=8 (velocity=0).
REQ-028 SHALL cover base rate: count_map=1, velocity=0 -> move_map high after enabled edges 8, 16, 24, each 1 cycle wide; period=8.
REQ-029 SHALL cover a velocity change mid-count: at counter=5 set velocity=3 -> period=2, move_map on the next edge, then every 2 edges.
REQ-030 SHALL cover level progression: velocity=0, count_map=1 for 120 edges.
- level=1, 2, 3 after edges 30, 60, 90, each with a level_up pulse.
- No level_up at edge 120; level stays 3.
- With velocity=3: period=2 (saturated, no wrap).
REQ-031 SHALL cover pause: count_map=0 for 10 edges mid-count -> counters and level frozen, no pulses; pulse spacing preserved after resume.
REQ-032 SHALL cover clear and reset mid-run:
- clear_level=1 at level=2 -> level=0, counters 0, move_map=0 that cycle; next pulse 8 enabled edges later.
- reset=0 with clear_level=1 and count_map=1 -> all outputs at reset values.

Source files
------------

// File: rtl/map_speed_scheduler.sv
// map_speed_scheduler
//   Paces map scrolling for a runner-style game. A move period is derived
//   from the current difficulty level plus the player's velocity request.
//   move_map pulses once per period, and the level advances every
//   LEVEL_TICKS enabled ticks until it saturates.
//
// Ports
//   clock       : single clock, all state updates on its rising edge
//   reset       : synchronous active-low reset (0 = reset)
//   count_map   : run enable; 0 freezes counters, level and pulses
//   velocity    : player speed request, added to the level to form speed
//   clear_level : synchronous restart of level and both counters
//   move_map    : one-cycle pulse each time a move period elapses
//   level_up    : one-cycle pulse on each level increment
//   level       : current difficulty level
//   period      : current move period in ticks (combinational)
module map_speed_scheduler #(
  parameter int VEL_W       = 2,
  parameter int LEVEL_W     = 2,
  parameter int CNT_W       = 16,
  parameter int BASE_PERIOD = 800,
  parameter int STEP        = 100,
  parameter int MIN_PERIOD  = 200,
  parameter int LEVEL_TICKS = 30000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               count_map,
  input  logic [VEL_W-1:0]   velocity,
  input  logic               clear_level,
  output logic               move_map,
  output logic               level_up,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   period
);

  localparam int SPD_W = ((LEVEL_W > VEL_W) ? LEVEL_W : VEL_W) + 1;

  logic [SPD_W-1:0] speed;
  logic [31:0]      reduction;
  logic [31:0]      raw_period;
  logic [CNT_W-1:0] move_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic             move_due;
  logic             tick_due;
  logic             level_max;

  // Saturating subtract, then floor at MIN_PERIOD, all in 32-bit space
  // so a large STEP*speed can never wrap into a long period.
  always_comb begin
    speed      = SPD_W'(level) + SPD_W'(velocity);
    reduction  = 32'(STEP) * 32'(speed);
    raw_period = (reduction >= 32'(BASE_PERIOD)) ? '0
                                                 : 32'(BASE_PERIOD) - reduction;
    period     = (raw_period > 32'(MIN_PERIOD)) ? CNT_W'(raw_period)
                                                : CNT_W'(MIN_PERIOD);
  end

  // ">=" rather than "==" so a period that shrinks below the running
  // count fires on the next enabled edge instead of wrapping the counter.
  always_comb begin
    move_due  = (move_cnt >= (period - CNT_W'(1)));
    tick_due  = (tick_cnt == CNT_W'(LEVEL_TICKS - 1));
    level_max = (level == '1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      move_cnt <= '0;
      tick_cnt <= '0;
      level    <= '0;
      move_map <= 1'b0;
      level_up <= 1'b0;
    end else if (clear_level) begin
      move_cnt <= '0;
      tick_cnt <= '0;
      level    <= '0;
      move_map <= 1'b0;
      level_up <= 1'b0;
    end else if (count_map) begin
      if (move_due) begin
        move_cnt <= '0;
        move_map <= 1'b1;
      end else begin
        move_cnt <= move_cnt + CNT_W'(1);
        move_map <= 1'b0;
      end

      if (tick_due) begin
        tick_cnt <= '0;
        if (!level_max) begin
          level    <= level + LEVEL_W'(1);
          level_up <= 1'b1;
        end else begin
          level_up <= 1'b0;
        end
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
        level_up <= 1'b0;
      end
    end else begin
      move_map <= 1'b0;
      level_up <= 1'b0;
    end
  end

endmodule

// File: tb/tb_map_speed_scheduler.sv
module tb_map_speed_scheduler;

  localparam int BASE  = 8;
  localparam int STEPV = 2;
  localparam int MINP  = 2;
  localparam int LT    = 30;
  localparam int MAXL  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       count_map = 1'b0;
  logic       clear_level = 1'b0;
  logic [1:0] velocity = 2'd0;
  logic       move_map;
  logic       level_up;
  logic [1:0] level;
  logic [7:0] period;

  int checks = 0;
  int errors = 0;

  // Reference model state: ticks since last move, enabled ticks since
  // clear/reset, and the expected registered outputs.
  int m_cnt   = 0;
  int m_total = 0;
  int m_lvl   = 0;
  bit m_move  = 0;
  bit m_lup   = 0;

  map_speed_scheduler #(
    .VEL_W(2), .LEVEL_W(2), .CNT_W(8), .BASE_PERIOD(BASE), .STEP(STEPV),
    .MIN_PERIOD(MINP), .LEVEL_TICKS(LT)
  ) dut (
    .clock(clock), .reset(reset), .count_map(count_map), .velocity(velocity),
    .clear_level(clear_level), .move_map(move_map), .level_up(level_up),
    .level(level), .period(period)
  );

  always #5 clock = ~clock;

  function automatic int exp_period(input int l, input int v);
    int p;
    p = BASE - STEPV * (l + v);
    if (p < MINP) p = MINP;
    return p;
  endfunction

  // Drive one edge worth of inputs and advance the reference model.
  task automatic tick(input bit rst, input bit clr, input bit en, input int vel);
    int p;
    reset = rst; clear_level = clr; count_map = en; velocity = 2'(vel);
    @(posedge clock);
    if (!rst || clr) begin
      m_cnt = 0; m_total = 0; m_lvl = 0; m_move = 0; m_lup = 0;
    end else if (en) begin
      p = exp_period(m_lvl, vel);
      if (m_cnt >= p - 1) begin m_cnt = 0; m_move = 1; end
      else begin m_cnt = m_cnt + 1; m_move = 0; end
      m_total = m_total + 1;
      m_lup = (m_total % LT == 0) && (m_total / LT <= MAXL);
      m_lvl = (m_total / LT > MAXL) ? MAXL : m_total / LT;
    end else begin
      m_move = 0; m_lup = 0;
    end
    #1;
  endtask

  task automatic test_reset;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++; if (move_map !== 1'b0) begin errors++; $display("FAIL reset_move got %0b want 0", move_map); end
    checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL reset_lup got %0b want 0", level_up); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (period !== 8'd8) begin errors++; $display("FAIL reset_period got %0d want 8", period); end
  endtask

  task automatic test_base_rate;
    bit want;
    tick(1, 1, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      tick(1, 0, 1, 0);
      want = (i % 8 == 0);
      checks++; if (move_map !== want) begin errors++; $display("FAIL base_move edge %0d got %0b want %0b", i, move_map, want); end
      checks++; if (period !== 8'd8) begin errors++; $display("FAIL base_period edge %0d got %0d want 8", i, period); end
    end
  endtask

  task automatic test_velocity_change;
    bit want;
    tick(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, 0);
    velocity = 2'd3;
    #1;
    checks++; if (period !== 8'd2) begin errors++; $display("FAIL vel_period got %0d want 2", period); end
    for (int i = 1; i <= 6; i++) begin
      tick(1, 0, 1, 3);
      want = (i % 2 == 1);
      checks++; if (move_map !== want) begin errors++; $display("FAIL vel_move edge %0d got %0b want %0b", i, move_map, want); end
    end
  endtask

  task automatic test_level;
    bit want_up;
    int want_lvl;
    tick(1, 1, 0, 0);
    for (int i = 1; i <= 120; i++) begin
      tick(1, 0, 1, 0);
      want_up  = (i == 30) || (i == 60) || (i == 90);
      want_lvl = (i / 30 > 3) ? 3 : i / 30;
      checks++; if (level_up !== want_up) begin errors++; $display("FAIL level_up edge %0d got %0b want %0b", i, level_up, want_up); end
      checks++; if (level !== 2'(want_lvl)) begin errors++; $display("FAIL level edge %0d got %0d want %0d", i, level, want_lvl); end
      checks++; if (move_map !== m_move) begin errors++; $display("FAIL level_move edge %0d got %0b want %0b", i, move_map, m_move); end
    end
    velocity = 2'd3;
    #1;
    checks++; if (period !== 8'd2) begin errors++; $display("FAIL level_sat_period got %0d want 2", period); end
  endtask

  task automatic test_pause;
    bit want;
    tick(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0, 0);
      checks++; if (move_map !== 1'b0 || level_up !== 1'b0) begin errors++; $display("FAIL pause_pulse edge %0d got %0b%0b want 00", i, move_map, level_up); end
      checks++; if (level !== 2'd0) begin errors++; $display("FAIL pause_level got %0d want 0", level); end
    end
    for (int i = 1; i <= 12; i++) begin
      tick(1, 0, 1, 0);
      want = (i == 4) || (i == 12);
      checks++; if (move_map !== want) begin errors++; $display("FAIL resume_move edge %0d got %0b want %0b", i, move_map, want); end
    end
  endtask

  task automatic test_clear;
    bit want;
    tick(1, 1, 0, 0);
    for (int i = 0; i < 60; i++) tick(1, 0, 1, 0);
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL clear_pre_level got %0d want 2", level); end
    tick(1, 1, 1, 0);
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL clear_level got %0d want 0", level); end
    checks++; if (move_map !== 1'b0 || level_up !== 1'b0) begin errors++; $display("FAIL clear_pulse got %0b%0b want 00", move_map, level_up); end
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0, 1, 0);
      want = (i == 8);
      checks++; if (move_map !== want) begin errors++; $display("FAIL clear_next_move edge %0d got %0b want %0b", i, move_map, want); end
    end
  endtask

  task automatic test_reset_mid;
    tick(1, 1, 0, 0);
    for (int i = 0; i < 37; i++) tick(1, 0, 1, 2);
    tick(0, 1, 1, 0);
    checks++; if (move_map !== 1'b0 || level_up !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got %0b%0b want 00", move_map, level_up); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL rstmid_level got %0d want 0", level); end
    checks++; if (period !== 8'd8) begin errors++; $display("FAIL rstmid_period got %0d want 8", period); end
  endtask

  task automatic test_random;
    bit rst, clr, en;
    int vel, wp;
    tick(1, 1, 0, 0);
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 149) == 0);
      en  = ($urandom_range(0, 3) != 0);
      vel = (i % 40 < 20) ? int'($urandom_range(0, 3)) : (i / 40) % 4;
      tick(rst, clr, en, vel);
      wp = exp_period(m_lvl, vel);
      checks++; if (move_map !== m_move) begin errors++; $display("FAIL rand_move cyc %0d got %0b want %0b", i, move_map, m_move); end
      checks++; if (level_up !== m_lup) begin errors++; $display("FAIL rand_lup cyc %0d got %0b want %0b", i, level_up, m_lup); end
      checks++; if (level !== 2'(m_lvl)) begin errors++; $display("FAIL rand_level cyc %0d got %0d want %0d", i, level, m_lvl); end
      checks++; if (period !== 8'(wp)) begin errors++; $display("FAIL rand_period cyc %0d got %0d want %0d", i, period, wp); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_base_rate();
    test_velocity_change();
    test_level();
    test_pause();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
